// File: rtl/mlp_param_loader.sv
// Serial parameter loader for the MLP: streams fixed-point words into
// the registered weight and bias arrays, then flags that the set is complete.
module mlp_param_loader #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic signed [WM+WN-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic signed [M-2:0][N-1:0][N-1:0][WM+WN-1:0] w,
  output logic signed [M-2:0][N-1:0][QM+QN-1:0] b,
  output logic busy,
  output logic weight_flag
);

  localparam int DW = WM + WN;
  localparam int BW = QM + QN;
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [LW-1:0] L_LAST = LW'(M - 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [LW-1:0] l;
  logic [NW-1:0] j;
  logic [NW-1:0] i;

  logic xfer;
  logic i_last;
  logic j_last;
  logic l_last;
  logic signed [DW-1:0] word;
  logic signed [BW-1:0] bias_word;

  assign xfer   = in_valid & in_ready;
  assign i_last = (i == N_LAST);
  assign j_last = (j == N_LAST);
  assign l_last = (l == L_LAST);
  assign word   = in_data;

  // Bit-pattern resize only: sign-extend or drop MSBs, no re-scaling.
  assign bias_word = BW'(word);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    weight_flag = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD_W;
        end
      end
      LOAD_W: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && i_last && j_last) begin
          state_nx = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && j_last) begin
          state_nx = l_last ? DONE : LOAD_W;
        end
      end
      DONE: begin
        weight_flag = 1'b1;
        state_nx    = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l <= '0;
      j <= '0;
      i <= '0;
      w <= '0;
      b <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            l <= '0;
            j <= '0;
            i <= '0;
          end
        end
        LOAD_W: begin
          if (xfer) begin
            w[l][j][i] <= word;
            if (i_last) begin
              i <= '0;
              j <= j_last ? '0 : j + 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            b[l][j] <= bias_word;
            if (j_last) begin
              j <= '0;
              l <= l_last ? '0 : l + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        DONE: begin
          l <= '0;
          j <= '0;
          i <= '0;
        end
        default: begin
          l <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_param_loader.sv
// Directed bench for mlp_param_loader: a default 2-layer instance and a
// 3-layer instance with a wider bias format to exercise sign extension.
module tb_mlp_param_loader;

  logic clk = 1'b0;
  logic rst;

  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [31:0] w;
  logic [15:0] b;
  logic       busy;
  logic       weight_flag;

  logic       start3;
  logic [7:0] in_data3;
  logic       in_valid3;
  logic       in_ready3;
  logic [63:0] w3;
  logic [35:0] b3;
  logic       busy3;
  logic       weight_flag3;

  int n_cmp = 0;
  int n_bad = 0;
  int flags = 0;
  int flags3 = 0;

  always #5 clk = ~clk;

  mlp_param_loader dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .w(w),
    .b(b),
    .busy(busy),
    .weight_flag(weight_flag)
  );

  mlp_param_loader #(.M(3), .N(2), .QM(4), .QN(5)) dut3 (
    .clk(clk),
    .rst(rst),
    .start(start3),
    .in_data(in_data3),
    .in_valid(in_valid3),
    .in_ready(in_ready3),
    .w(w3),
    .b(b3),
    .busy(busy3),
    .weight_flag(weight_flag3)
  );

  always @(posedge clk) begin
    if (weight_flag) flags++;
    if (weight_flag3) flags3++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Default instance: six words, optional two-cycle gaps, optional
  // start held high for the whole load including the DONE cycle.
  task automatic load2(input logic [7:0] wd [6], input bit gap,
                       input bit spur);
    start = 1'b1;
    tick();
    start = spur;
    for (int k = 0; k < 6; k++) begin
      chk("ready_w", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_data  = wd[k];
      tick();
      if (gap && k < 5) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        chk("busy_gap", {63'd0, busy}, 64'd1);
        tick();
        chk("busy_gap2", {63'd0, busy}, 64'd1);
        tick();
      end
    end
    in_valid = 1'b0;
    chk("flag_pulse", {63'd0, weight_flag}, 64'd1);
    chk("ready_done", {63'd0, in_ready}, 64'd0);
    tick();
    start = 1'b0;
    chk("flag_low", {63'd0, weight_flag}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    tick();
    chk("stay_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic load3(input logic [7:0] wd [12]);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("ready3", {63'd0, in_ready3}, 64'd1);
      in_valid3 = 1'b1;
      in_data3  = wd[k];
      tick();
      if (k == 5) chk("mid_busy3", {63'd0, busy3}, 64'd1);
    end
    in_valid3 = 1'b0;
    chk("flag3", {63'd0, weight_flag3}, 64'd1);
    tick();
    chk("flag3_low", {63'd0, weight_flag3}, 64'd0);
  endtask

  logic [7:0] v6 [6];
  logic [7:0] v12 [12];

  initial begin
    rst = 1'b1;
    start = 1'b0; in_data = '0; in_valid = 1'b0;
    start3 = 1'b0; in_data3 = '0; in_valid3 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_flag", {63'd0, weight_flag}, 64'd0);
      chk("rst_w", {32'd0, w}, 64'd0);
      chk("rst_b", {48'd0, b}, 64'd0);
      tick();
    end
    chk("rst_w3", w3, 64'd0);
    in_valid = 1'b0;

    // Continuous default load
    flags = 0;
    v6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load2(v6, 1'b0, 1'b0);
    chk("w000", {56'd0, w[7:0]}, 64'h01);
    chk("w001", {56'd0, w[15:8]}, 64'h02);
    chk("w010", {56'd0, w[23:16]}, 64'h03);
    chk("w011", {56'd0, w[31:24]}, 64'h04);
    chk("b00", {56'd0, b[7:0]}, 64'h05);
    chk("b01", {56'd0, b[15:8]}, 64'h06);
    chk("flags_cont", 64'(flags), 64'd1);

    // Backpressure gaps, rewriting with new values
    flags = 0;
    v6 = '{8'hA1, 8'h72, 8'hF3, 8'h14, 8'h85, 8'h7F};
    load2(v6, 1'b1, 1'b0);
    chk("w_gap", {32'd0, w}, 64'h14F372A1);
    chk("b_gap", {48'd0, b}, 64'h7F85);
    chk("flags_gap", 64'(flags), 64'd1);

    // Reset three transfers into a load
    flags = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = 8'h30 + 8'(k);
      tick();
    end
    chk("part_w", {32'd0, w}, 64'h14323130);
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_w", {32'd0, w}, 64'd0);
    chk("abort_b", {48'd0, b}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    tick();
    tick();
    in_valid = 1'b0;
    chk("abort_flags", 64'(flags), 64'd0);
    v6 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    load2(v6, 1'b0, 1'b0);
    chk("reload_w", {32'd0, w}, 64'h24232221);
    chk("reload_b", {48'd0, b}, 64'h2625);
    chk("reload_flags", 64'(flags), 64'd1);

    // start held through LOAD_W, LOAD_B and DONE
    flags = 0;
    v6 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    load2(v6, 1'b0, 1'b1);
    chk("spur_w", {32'd0, w}, 64'h44434241);
    chk("spur_b", {48'd0, b}, 64'h4645);
    chk("spur_flags", 64'(flags), 64'd1);

    // Three-layer instance, positive biases
    flags3 = 0;
    for (int k = 0; k < 12; k++) v12[k] = 8'h10 + 8'(k);
    load3(v12);
    chk("w3", w3, 64'h19181716_13121110);
    chk("b3", {28'd0, b3}, {28'd0, 9'h01B, 9'h01A, 9'h015, 9'h014});
    chk("flags3", 64'(flags3), 64'd1);

    // Negative biases sign-extend into the 9-bit format
    flags3 = 0;
    v12 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h84, 8'hF5,
            8'h16, 8'h17, 8'h18, 8'h19, 8'h7A, 8'h80};
    load3(v12);
    chk("b3_sext", {28'd0, b3}, {28'd0, 9'h180, 9'h07A, 9'h1F5, 9'h184});
    chk("flags3_b", 64'(flags3), 64'd1);
    chk("w_hold", {32'd0, w}, 64'h44434241);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
